topk_drain: RTL and testbench

- Stream statistics block: ingests unsigned samples and keeps the K largest values seen since the last reset or drain.
- On a drain request, reads the held values out largest-first over a valid/ready stream, then clears itself.
- Complements the running second-largest tracker. That block produces one statistic per cycle; this block sits downstream of the same sample bus and hands a ranked snapshot to a consumer that can apply backpressure.

---
 rtl/topk_pkg.sv | 16 +
 rtl/topk_sorted_insert.sv | 54 +++++
 rtl/topk_drain.sv | 119 +++++++++++
 tb/tb_topk_drain.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/topk_pkg.sv
// Shared types for the top-K drain block.
// Latency: n/a (types and helper only).
// Backpressure: n/a.
package topk_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    // Width of count/idx: must hold the values 0..k inclusive.
    function automatic int cnt_width(input int k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/topk_sorted_insert.sv
// Combinational sorted insert of one sample into a K-entry non-increasing list.
// Latency: 0 cycles (pure combinational network).
// Backpressure: none; the caller decides whether to commit the result.
// Ports: entries/count = current list, in_data = new sample,
//        entries_nxt/count_nxt = list and count after insertion.
module topk_sorted_insert
    import topk_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4,
    parameter int CNT_W      = cnt_width(K)
) (
    input  logic [K*DATA_WIDTH-1:0] entries,
    input  logic [CNT_W-1:0]        count,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic [K*DATA_WIDTH-1:0] entries_nxt,
    output logic [CNT_W-1:0]        count_nxt
);

    // keep[i]: slot i is occupied and its value is >= the new sample, so it
    // stays put. Because the list is sorted the mask is a prefix; equal values
    // stay ahead of the new sample. When the list is full and the sample is
    // not larger than the tail, every slot keeps and the sample falls off.
    logic [K-1:0] keep;

    always_comb begin
        keep        = '0;
        entries_nxt = entries;
        for (int i = 0; i < K; i++) begin
            keep[i] = (CNT_W'(i) < count) &&
                      (entries[i*DATA_WIDTH +: DATA_WIDTH] >= in_data);
        end

        // Slot 0 is either kept or takes the new value; nothing shifts into it.
        if (!keep[0]) begin
            entries_nxt[0 +: DATA_WIDTH] = in_data;
        end

        // Other slots: keep, take the new value at the mask boundary, or
        // shift down from the slot above.
        for (int i = 1; i < K; i++) begin
            if (keep[i]) begin
                entries_nxt[i*DATA_WIDTH +: DATA_WIDTH] = entries[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (keep[i-1]) begin
                entries_nxt[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
            end else begin
                entries_nxt[i*DATA_WIDTH +: DATA_WIDTH] = entries[(i-1)*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        count_nxt = (count == CNT_W'(K)) ? count : count + CNT_W'(1);
    end

endmodule

// File: rtl/topk_drain.sv
// Keeps the K largest samples seen and streams them out largest-first on drain.
// Latency: insert visible 1 cycle after in_valid; first beat 1 cycle after drain.
// Backpressure: out_data/out_last held while out_ready=0; input side never stalls.
// Ports: clk/resetn (sync, active-low); in_valid/in_data sample input; drain
//        request; out_valid/out_data/out_last/out_ready stream; busy; count.
module topk_drain
    import topk_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              in_valid,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              drain,
    output logic                              out_valid,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_last,
    input  logic                              out_ready,
    output logic                              busy,
    output logic [cnt_width(K)-1:0]           count
);

    localparam int CNT_W = cnt_width(K);

    state_t                  state_q, state_d;
    logic [K*DATA_WIDTH-1:0] entries_q, entries_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [CNT_W-1:0]        idx_q, idx_d;

    logic [K*DATA_WIDTH-1:0] ins_entries;
    logic [CNT_W-1:0]        ins_count;
    logic                    is_last;
    logic [DATA_WIDTH-1:0]   sel_data;

    topk_sorted_insert #(
        .DATA_WIDTH (DATA_WIDTH),
        .K          (K),
        .CNT_W      (CNT_W)
    ) u_insert (
        .entries     (entries_q),
        .count       (count_q),
        .in_data     (in_data),
        .entries_nxt (ins_entries),
        .count_nxt   (ins_count)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < K; i++) begin
            if (idx_q == CNT_W'(i)) begin
                sel_data = entries_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        entries_d = entries_q;
        count_d   = count_q;
        idx_d     = idx_q;
        is_last   = (idx_q == count_q - CNT_W'(1));

        if (state_q == COLLECT) begin
            if (in_valid) begin
                entries_d = ins_entries;
                count_d   = ins_count;
            end
            // Decide on the post-insert count so a same-cycle sample can
            // turn an empty list into a one-beat drain.
            if (drain && (count_d != '0)) begin
                state_d = DRAIN;
                idx_d   = '0;
            end
        end else begin
            // Samples are dropped here, including on the final beat.
            if (out_ready) begin
                if (is_last) begin
                    state_d   = COLLECT;
                    entries_d = '0;
                    count_d   = '0;
                    idx_d     = '0;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        count     = count_q;
        if (state_q == DRAIN) begin
            out_valid = 1'b1;
            out_data  = sel_data;
            out_last  = is_last;
            busy      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= COLLECT;
            entries_q <= '0;
            count_q   <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            entries_q <= entries_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
        end
    end

endmodule

// File: tb/tb_topk_drain.sv
// Self-checking bench for topk_drain: queue-based reference model plus
// scripted scenarios with literal expectations, then a randomized run.
module tb_topk_drain;

    localparam int DW = 32;
    localparam int K  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          drain = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic [CW-1:0] count;

    topk_drain #(.DATA_WIDTH(DW), .K(K)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .drain     (drain),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .count     (count)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int nchk = 0;
    int cyc  = 0;
    bit chk_en = 1'b0;

    // Reference model: held values as a queue kept in descending order.
    int unsigned m_q[$];
    bit          m_drn = 1'b0;
    int          m_idx = 0;

    // Beats observed from the DUT and produced by the model.
    int unsigned got[$];
    bit          gotl[$];
    int          gotc[$];
    int unsigned mgot[$];
    int unsigned exp_q[$];

    task automatic check(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!resetn) begin
            m_q.delete();
            m_drn = 1'b0;
            m_idx = 0;
        end else if (!m_drn) begin
            if (in_valid) begin
                m_q.push_back(in_data);
                m_q.rsort();
                if (m_q.size() > K) void'(m_q.pop_back());
            end
            if (drain && m_q.size() > 0) begin
                m_drn = 1'b1;
                m_idx = 0;
            end
        end else if (out_ready) begin
            mgot.push_back(m_q[m_idx]);
            if (m_idx == m_q.size() - 1) begin
                m_q.delete();
                m_drn = 1'b0;
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_out_valid", out_valid, m_drn);
            check("cmp_busy", busy, m_drn);
            check("cmp_count", count, m_q.size());
            if (m_drn && out_valid) begin
                check("cmp_out_data", out_data, m_q[m_idx]);
                check("cmp_out_last", out_last, (m_idx == m_q.size() - 1));
            end
            if (resetn && out_valid && out_ready) begin
                got.push_back(out_data);
                gotl.push_back(out_last);
                gotc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int unsigned v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic clr();
        got.delete();
        gotl.delete();
        gotc.delete();
        mgot.delete();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("drain_completes", busy, 0);
    endtask

    task automatic req_drain();
        drain = 1'b1;
        tick();
        drain = 1'b0;
    endtask

    // Compare DUT beats and model beats against the literal list in exp_q.
    task automatic expect_seq(input string nm);
        check({nm, "_nbeats"}, got.size(), exp_q.size());
        check({nm, "_model_nbeats"}, mgot.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) begin
                check({nm, "_beat"}, got[i], exp_q[i]);
                check({nm, "_last"}, gotl[i], (i == exp_q.size() - 1));
            end
            if (i < mgot.size()) check({nm, "_model_beat"}, mgot[i], exp_q[i]);
        end
    endtask

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_out_data", out_data, 0);
        resetn = 1'b1;
        tick();

        // 1: duplicates and overflow of the top-4 set.
        out_ready = 1'b1;
        push(5); push(9); push(3); push(9); push(1); push(7);
        check("t1_count_before", count, 4);
        clr();
        req_drain();
        wait_idle();
        exp_q = '{9, 9, 7, 5};
        expect_seq("t1");
        if (gotc.size() == 4) begin
            for (int i = 1; i < 4; i++) check("t1_consecutive", gotc[i] - gotc[0], i);
        end
        check("t1_count_after", count, 0);
        check("t1_busy_after", busy, 0);

        // 2: partial fill.
        push(8); push(4);
        check("t2_count_before", count, 2);
        clr();
        req_drain();
        wait_idle();
        exp_q = '{8, 4};
        expect_seq("t2");
        check("t2_count_after", count, 0);

        // 3: backpressure after the first handshake.
        push(10); push(2); push(20); push(15);
        clr();
        req_drain();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_data", out_data, 15);
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_last", out_last, 0);
            tick();
        end
        out_ready = 1'b1;
        wait_idle();
        exp_q = '{20, 15, 10, 2};
        expect_seq("t3");

        // 4: empty drain ignored; drain with same-cycle sample gives one beat.
        clr();
        req_drain();
        for (int i = 0; i < 5; i++) begin
            check("t4_empty_valid", out_valid, 0);
            tick();
        end
        in_valid = 1'b1;
        in_data  = 6;
        drain    = 1'b1;
        tick();
        in_valid = 1'b0;
        drain    = 1'b0;
        wait_idle();
        exp_q = '{6};
        expect_seq("t4");

        // 5: sample during drain is dropped.
        push(3); push(2);
        clr();
        req_drain();
        in_valid = 1'b1;
        in_data  = 100;
        tick();
        in_valid = 1'b0;
        wait_idle();
        exp_q = '{3, 2};
        expect_seq("t5");
        check("t5_count_after", count, 0);
        clr();
        req_drain();
        tick();
        check("t5_no_redrain", got.size(), 0);
        check("t5_busy", busy, 0);

        // 6: reset during the second beat.
        push(11); push(22); push(33); push(44);
        clr();
        req_drain();
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("t6_valid_after_rst", out_valid, 0);
        check("t6_count_after_rst", count, 0);
        check("t6_beats_before_rst", got.size(), 1);
        clr();
        req_drain();
        for (int i = 0; i < 4; i++) begin
            check("t6_no_beats", out_valid, 0);
            tick();
        end

        // Randomized run against the model.
        for (int i = 0; i < 4000; i++) begin
            in_valid  = ($urandom % 2) == 0;
            in_data   = ($urandom % 4 == 0) ? $urandom : $urandom_range(0, 15);
            drain     = ($urandom % 8) == 0;
            out_ready = ($urandom % 4) != 0;
            resetn    = ($urandom % 300) != 0;
            tick();
        end
        in_valid  = 1'b0;
        drain     = 1'b0;
        resetn    = 1'b1;
        out_ready = 1'b1;
        wait_idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
